// File: rtl/mod_updown_counter.sv
// Synchronous modulo-N up/down counter with parallel load, terminal count and wrap reporting.
// Define MOD_UPDOWN_COUNTER_SATURATE_EN to make the counter saturate at its ends instead of wrapping.
module mod_updown_counter #(
  parameter int    WIDTH   = 3,
  parameter longint MODULUS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf_sticky
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] next_count;
  logic             wrap_set;
  logic             at_max;
  logic             at_zero;

  assign at_max  = (count == MAX_VAL);
  assign at_zero = (count == '0);

  // The edge that wraps (or saturates) is exactly the edge tc predicts.
  assign tc = en & ~load & ((up_dn & at_max) | (~up_dn & at_zero));

  always_comb begin
    next_count = count;
    wrap_set   = 1'b0;
    if (load) begin
      next_count = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (en) begin
      if (up_dn) begin
        if (at_max) begin
          wrap_set = 1'b1;
`ifdef MOD_UPDOWN_COUNTER_SATURATE_EN
          next_count = MAX_VAL;
`else
          next_count = '0;
`endif
        end else begin
          next_count = count + ONE;
        end
      end else begin
        if (at_zero) begin
          wrap_set = 1'b1;
`ifdef MOD_UPDOWN_COUNTER_SATURATE_EN
          next_count = '0;
`else
          next_count = MAX_VAL;
`endif
        end else begin
          next_count = count - ONE;
        end
      end
    end
  end

  // A new wrap beats a simultaneous clear so no overflow event is ever lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      wrap       <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      count <= next_count;
      wrap  <= wrap_set;
      if (wrap_set) begin
        ovf_sticky <= 1'b1;
      end else if (clr_ovf) begin
        ovf_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed self-checking bench: a MODULUS=6 counter and a MODULUS=8 counter driven from shared inputs.
module tb_mod_updown_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [2:0] load_val;
  logic       clr_ovf;

  logic [2:0] count6;
  logic       tc6;
  logic       wrap6;
  logic       ovf6;
  logic [2:0] count8;
  logic       tc8;
  logic       wrap8;
  logic       ovf8;

  int tests_run;
  int tests_failed;

`ifdef MOD_UPDOWN_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  mod_updown_counter #(.WIDTH(3), .MODULUS(6)) dut6 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .clr_ovf(clr_ovf),
    .count(count6), .tc(tc6), .wrap(wrap6), .ovf_sticky(ovf6)
  );

  mod_updown_counter #(.WIDTH(3), .MODULUS(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .clr_ovf(clr_ovf),
    .count(count8), .tc(tc8), .wrap(wrap8), .ovf_sticky(ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic ud, input logic ld,
                               input logic [2:0] lv, input logic clr);
    en       = e;
    up_dn    = ud;
    load     = ld;
    load_val = lv;
    clr_ovf  = clr;
    #1;
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tickClock();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] up_seq [7];
  logic [2:0] dn_seq [3];

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    up_seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
    dn_seq = '{3'd0, 3'd5, 3'd4};

    rst = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    #12;
    checkOutput("reset_count", count6, 0);
    checkOutput("reset_wrap", wrap6, 0);
    checkOutput("reset_ovf", ovf6, 0);

    // Bring the count to 4, then reset asynchronously between edges.
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd4, 1'b0);
    tickClock();
    checkOutput("load4", count6, 4);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_count", count6, 0);
    checkOutput("async_rst_wrap", wrap6, 0);
    checkOutput("async_rst_ovf", ovf6, 0);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
    tickClock();
    checkOutput("first_count_after_rst", count6, 1);

    // Up wrap from zero.
    applyStimulus(1'b1, 1'b1, 1'b1, 3'd0, 1'b0);
    tickClock();
    checkOutput("load0_count", count6, 0);
    checkOutput("load0_wrap", wrap6, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      checkOutput($sformatf("up_tc_%0d", i), tc6, (i == 5) ? 1 : 0);
      tickClock();
      checkOutput($sformatf("up_count_%0d", i), count6, up_seq[i]);
      checkOutput($sformatf("up_wrap_%0d", i), wrap6, (i == 5) ? 1 : 0);
    end
    checkOutput("up_ovf_set", ovf6, 1);

    // Down wrap then direction flip.
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("dn_tc_%0d", i), tc6, (i == 1) ? 1 : 0);
      tickClock();
      checkOutput($sformatf("dn_count_%0d", i), count6, dn_seq[i]);
      checkOutput($sformatf("dn_wrap_%0d", i), wrap6, (i == 1) ? 1 : 0);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
    tickClock();
    checkOutput("flip_count", count6, 5);
    checkOutput("flip_wrap", wrap6, 0);

    // Load priority and clamp.
    applyStimulus(1'b1, 1'b1, 1'b1, 3'd3, 1'b0);
    checkOutput("load_masks_tc", tc6, 0);
    tickClock();
    checkOutput("load3_count", count6, 3);
    checkOutput("load3_wrap", wrap6, 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 3'd7, 1'b0);
    tickClock();
    checkOutput("clamp_count6", count6, 5);
    checkOutput("clamp_wrap6", wrap6, 0);
    checkOutput("load7_count8", count8, 7);
    checkOutput("ovf_held", ovf6, 1);

    // Hold with clear, then the set/clear race.
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 1'b1);
    checkOutput("hold_tc", tc6, 0);
    tickClock();
    checkOutput("hold_count", count6, 5);
    checkOutput("clr_ovf", ovf6, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 1'b1);
    tickClock();
    checkOutput("race_count", count6, 0);
    checkOutput("race_wrap", wrap6, 1);
    checkOutput("race_ovf", ovf6, 1);
    checkOutput("race_count8", count8, SAT ? 7 : 0);
    checkOutput("race_wrap8", wrap8, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 1'b1);
    tickClock();
    checkOutput("late_clr_ovf", ovf6, 0);
    checkOutput("late_clr_wrap", wrap6, 0);

    // Full-range counter at its top, counting up twice.
    applyStimulus(1'b1, 1'b1, 1'b1, 3'd7, 1'b0);
    tickClock();
    checkOutput("top8_count", count8, 7);
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
    checkOutput("top8_tc", tc8, 1);
    tickClock();
    checkOutput("top8_edge1_count", count8, SAT ? 7 : 0);
    checkOutput("top8_edge1_wrap", wrap8, 1);
    checkOutput("top8_edge1_ovf", ovf8, 1);
    tickClock();
    checkOutput("top8_edge2_count", count8, SAT ? 7 : 1);
    checkOutput("top8_edge2_wrap", wrap8, SAT ? 1 : 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
